// File: rtl/magic_pkg.sv
// Shared types and sizing for the MAGIC NOR/NOT sequencer.
// Instruction layout is {op, dst, src_a, src_b}, MSB first.
package magic_pkg;

  localparam int NCELLS     = 32;
  localparam int ADDR_W     = 5;
  localparam int PROG_DEPTH = 64;
  localparam int PC_W       = 6;
  localparam int INSTR_W    = 2 + 3 * ADDR_W;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_NOT  = 2'b01,
    OP_NOR  = 2'b10,
    OP_HALT = 2'b11
  } op_t;

  typedef struct packed {
    op_t               op;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
  } instr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_INIT,
    ST_EVAL,
    ST_DONE
  } state_t;

  // A MAGIC gate cannot use its own output cell as an operand.
  function automatic logic illegal_operands(instr_t i);
    return (i.dst == i.src_a) || ((i.op == OP_NOR) && (i.dst == i.src_b));
  endfunction

endpackage

// File: rtl/magic_nor_sequencer_if.sv
// Host/crossbar bundle of the sequencer: program load, cell access,
// control/status and the crossbar operation strobes.
interface magic_if;
  import magic_pkg::*;

  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_wdata;
  logic               cell_we;
  logic [ADDR_W-1:0]  cell_addr;
  logic               cell_wdata;
  logic               cell_rdata;
  logic               start;
  logic               busy;
  logic               done;
  logic               err;
  logic               xb_valid;
  logic               xb_phase;
  logic [ADDR_W-1:0]  xb_dst;
  logic [ADDR_W-1:0]  xb_src_a;
  logic [ADDR_W-1:0]  xb_src_b;
  logic [PC_W:0]      gate_count;

  modport master (
    output prog_we, prog_addr, prog_wdata, cell_we, cell_addr, cell_wdata, start,
    input  cell_rdata, busy, done, err, xb_valid, xb_phase,
           xb_dst, xb_src_a, xb_src_b, gate_count
  );

  modport slave (
    input  prog_we, prog_addr, prog_wdata, cell_we, cell_addr, cell_wdata, start,
    output cell_rdata, busy, done, err, xb_valid, xb_phase,
           xb_dst, xb_src_a, xb_src_b, gate_count
  );

endinterface

// File: rtl/magic_cell_array.sv
// Bit-accurate behavioural model of the memristor crossbar cells.
// Host writes win over crossbar operations; the sequencer never overlaps them.
module magic_cell_array
  import magic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic              ext_wdata,
  input  logic              init_en,
  input  logic              eval_en,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data
);

  logic [NCELLS-1:0] cells;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cells <= '0;
    end else if (ext_we) begin
      cells[ext_addr] <= ext_wdata;
    end else if (init_en) begin
      cells[dst] <= 1'b1;
    end else if (eval_en) begin
      // conditional reset: output cell can only fall from its INIT value
      cells[dst] <= cells[dst] & ~(cells[src_a] | cells[src_b]);
    end
  end

  assign rd_data = cells[rd_addr];

endmodule

// File: rtl/magic_nor_sequencer.sv
// Plays a NOR/NOT gate list from program memory as two-phase MAGIC
// crossbar operations (INIT then EVAL) on the behavioural cell array.
//
// state | meaning
// IDLE  | waiting for start; host may load program and cells
// FETCH | decode instr[pc]; skip NOP, stop on HALT or bad operands
// INIT  | crossbar sets cell[dst] to 1
// EVAL  | crossbar conditionally resets cell[dst]; advance pc
// DONE  | one-cycle done pulse
module magic_nor_sequencer
  import magic_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  magic_if.slave bus
);

  localparam logic [PC_W:0]   GC_MAX  = {1'b1, {PC_W{1'b0}}};
  localparam logic [PC_W-1:0] PC_LAST = {PC_W{1'b1}};

  state_t          state;
  logic [PC_W-1:0] pc;
  instr_t          prog_mem [PROG_DEPTH];
  instr_t          cur;
  logic            in_idle;
  logic            rd_data;

  assign in_idle = (state == ST_IDLE);
  assign cur     = prog_mem[pc];

  // Program memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we && in_idle) begin
      prog_mem[bus.prog_addr] <= instr_t'(bus.prog_wdata);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      pc             <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.xb_valid   <= 1'b0;
      bus.xb_phase   <= 1'b0;
      bus.xb_dst     <= '0;
      bus.xb_src_a   <= '0;
      bus.xb_src_b   <= '0;
      bus.gate_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state          <= ST_FETCH;
            pc             <= '0;
            bus.err        <= 1'b0;
            bus.gate_count <= '0;
            bus.busy       <= 1'b1;
          end
        end
        ST_FETCH: begin
          case (cur.op)
            OP_NOP: pc <= pc + 1'b1;
            OP_HALT: begin
              state    <= ST_DONE;
              bus.done <= 1'b1;
            end
            default: begin
              if (illegal_operands(cur)) begin
                state    <= ST_DONE;
                bus.err  <= 1'b1;
                bus.done <= 1'b1;
              end else begin
                state        <= ST_INIT;
                bus.xb_valid <= 1'b1;
                bus.xb_phase <= 1'b0;
                bus.xb_dst   <= cur.dst;
                bus.xb_src_a <= cur.src_a;
                bus.xb_src_b <= (cur.op == OP_NOT) ? cur.src_a : cur.src_b;
              end
            end
          endcase
        end
        ST_INIT: begin
          state        <= ST_EVAL;
          bus.xb_phase <= 1'b1;
        end
        ST_EVAL: begin
          bus.xb_valid <= 1'b0;
          bus.xb_phase <= 1'b0;
          if (bus.gate_count != GC_MAX) begin
            bus.gate_count <= bus.gate_count + 1'b1;
          end
          // running off the end of program memory without HALT is a fault
          if (pc == PC_LAST) begin
            state    <= ST_DONE;
            bus.err  <= 1'b1;
            bus.done <= 1'b1;
          end else begin
            state <= ST_FETCH;
            pc    <= pc + 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  magic_cell_array u_cells (
    .clk       (clk),
    .rst_n     (rst_n),
    .ext_we    (bus.cell_we && in_idle),
    .ext_addr  (bus.cell_addr),
    .ext_wdata (bus.cell_wdata),
    .init_en   (state == ST_INIT),
    .eval_en   (state == ST_EVAL),
    .dst       (bus.xb_dst),
    .src_a     (bus.xb_src_a),
    .src_b     (bus.xb_src_b),
    .rd_addr   (bus.cell_addr),
    .rd_data   (rd_data)
  );

  assign bus.cell_rdata = rd_data;

endmodule

// File: tb/tb_magic_nor_sequencer.sv
// Scoreboard bench: each program run pushes its expected completion record,
// a monitor checks it when done pulses; cell results are read back in IDLE.
module tb_magic_nor_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  magic_if bus ();

  magic_nor_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    cyc;
    int    gc;
    int    err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected done pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, " done cycle"}, cyc - t0, e.cyc);
        check({e.name, " gate_count"}, int'(bus.gate_count), e.gc);
        check({e.name, " err"}, int'(bus.err), e.err);
      end
    end
  end

  task automatic prog_w(input int addr, input logic [1:0] op, input int d, input int a, input int b);
    @(negedge clk);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = addr[5:0];
    bus.prog_wdata = {op, d[4:0], a[4:0], b[4:0]};
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  task automatic set_cell(input int addr, input logic v);
    @(negedge clk);
    bus.cell_we    = 1'b1;
    bus.cell_addr  = addr[4:0];
    bus.cell_wdata = v;
    @(negedge clk);
    bus.cell_we = 1'b0;
  endtask

  task automatic get_cell(input int addr, output int v);
    bus.cell_addr = addr[4:0];
    #1;
    v = int'(bus.cell_rdata);
  endtask

  task automatic expect_done(input string name, input int c, input int gc, input int e);
    exp_q.push_back('{name, c, gc, e});
  endtask

  // start sampled at the posedge ending cycle 0; afterwards cyc - t0 is the cycle number
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    bus.start = 1'b0;
  endtask

  task automatic wait_cycle(input int c);
    int n = 0;
    while ((cyc - t0) < c && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 1000);
    if (bus.busy) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: busy still %0d after %0d cycles", name, bus.busy, n);
    end
    check({name, " done reported"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  function automatic logic [1:0] c17_ref(input logic [4:0] in);
    logic g1, g2, g3, g6, g7, g10, g11, g16, g19;
    {g7, g6, g3, g2, g1} = in;
    g10 = ~(g1 & g3);
    g11 = ~(g3 & g6);
    g16 = ~(g2 & g11);
    g19 = ~(g11 & g7);
    return {~(g10 & g16), ~(g16 & g19)};
  endfunction

  task automatic load_c17();
    prog_w(0, 2'b01, 5, 0, 0);     // ~G1
    prog_w(1, 2'b01, 6, 1, 0);     // ~G2
    prog_w(2, 2'b01, 7, 2, 0);     // ~G3
    prog_w(3, 2'b01, 8, 3, 0);     // ~G6
    prog_w(4, 2'b01, 9, 4, 0);     // ~G7
    prog_w(5, 2'b10, 10, 5, 7);    // ~G10
    prog_w(6, 2'b10, 11, 7, 8);    // ~G11
    prog_w(7, 2'b10, 12, 6, 11);   // ~G16
    prog_w(8, 2'b10, 13, 11, 9);   // ~G19
    prog_w(9, 2'b10, 14, 10, 12);  // ~G22
    prog_w(10, 2'b10, 15, 12, 13); // ~G23
    prog_w(11, 2'b01, 16, 14, 0);  // G22
    prog_w(12, 2'b01, 17, 15, 0);  // G23
    prog_w(13, 2'b11, 0, 0, 0);
  endtask

  task automatic set_inputs(input logic [4:0] in);
    for (int i = 0; i < 5; i++) set_cell(i, in[i]);
  endtask

  task automatic check_c17(input string name, input logic [4:0] in);
    int v;
    logic [1:0] r;
    r = c17_ref(in);
    @(negedge clk);
    get_cell(16, v);
    check({name, " G22"}, v, int'(r[1]));
    get_cell(17, v);
    check({name, " G23"}, v, int'(r[0]));
  endtask

  initial begin
    int v;
    int nz;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_wdata = '0;
    bus.cell_we = 1'b0; bus.cell_addr = '0; bus.cell_wdata = 1'b0;
    bus.start = 1'b0;

    repeat (3) @(negedge clk);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset err", int'(bus.err), 0);
    check("reset xb_valid", int'(bus.xb_valid), 0);
    check("reset xb_dst", int'(bus.xb_dst), 0);
    check("reset gate_count", int'(bus.gate_count), 0);
    get_cell(9, v);
    check("reset cell9", v, 0);
    rst_n = 1'b1;

    // single NOR: cell1 = ~(cell2 | cell3) with cell2=1, cell3=0
    prog_w(0, 2'b10, 1, 2, 3);
    prog_w(1, 2'b11, 0, 0, 0);
    set_cell(1, 1'b0);
    set_cell(2, 1'b1);
    set_cell(3, 1'b0);
    bus.cell_addr = 5'd1;
    expect_done("nor1", 5, 1, 0);
    pulse_start();
    wait_cycle(2);
    check("nor1 c2 xb_valid", int'(bus.xb_valid), 1);
    check("nor1 c2 xb_phase", int'(bus.xb_phase), 0);
    check("nor1 c2 xb_dst", int'(bus.xb_dst), 1);
    check("nor1 c2 xb_src_b", int'(bus.xb_src_b), 3);
    check("nor1 c2 cell1", int'(bus.cell_rdata), 0);
    wait_cycle(3);
    check("nor1 c3 xb_valid", int'(bus.xb_valid), 1);
    check("nor1 c3 xb_phase", int'(bus.xb_phase), 1);
    check("nor1 c3 cell1 after init", int'(bus.cell_rdata), 1);
    wait_cycle(4);
    check("nor1 c4 xb_valid", int'(bus.xb_valid), 0);
    check("nor1 c4 cell1 after eval", int'(bus.cell_rdata), 0);
    wait_idle("nor1");

    // output cell aliased with an operand
    prog_w(0, 2'b10, 4, 4, 7);
    set_cell(4, 1'b0);
    expect_done("alias", 2, 0, 1);
    pulse_start();
    wait_idle("alias");
    get_cell(4, v);
    check("alias cell4 unchanged", v, 0);

    load_c17();
    set_inputs(5'b11111);
    expect_done("c17 ones", 41, 13, 0);
    pulse_start();
    check("c17 ones err cleared by start", int'(bus.err), 0);
    wait_idle("c17 ones");
    check_c17("c17 ones", 5'b11111);

    // start and prog_we while busy must both be ignored
    set_inputs(5'b00000);
    expect_done("c17 zeros", 41, 13, 0);
    pulse_start();
    wait_cycle(5);
    bus.start      = 1'b1;
    bus.prog_we    = 1'b1;
    bus.prog_addr  = 6'd13;
    bus.prog_wdata = {2'b01, 5'd1, 5'd0, 5'd0};
    @(negedge clk);
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    wait_idle("c17 zeros");
    check_c17("c17 zeros", 5'b00000);

    // reset during EVAL of gate 5 (cycle 3+3*5)
    set_inputs(5'b10101);
    pulse_start();
    wait_cycle(18);
    check("rst eval phase", int'(bus.xb_phase), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst busy", int'(bus.busy), 0);
    check("rst xb_valid", int'(bus.xb_valid), 0);
    check("rst gate_count", int'(bus.gate_count), 0);
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      get_cell(i, v);
      nz += v;
    end
    check("rst cells set", nz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst no done pending busy", int'(bus.busy), 0);

    // program memory survives reset
    set_inputs(5'b10101);
    expect_done("c17 post-reset", 41, 13, 0);
    pulse_start();
    wait_idle("c17 post-reset");
    check_c17("c17 post-reset", 5'b10101);

    // no HALT anywhere: runs off the end after 64 gates
    for (int i = 0; i < 64; i++) prog_w(i, 2'b01, 1, 0, 0);
    set_cell(0, 1'b1);
    set_cell(1, 1'b1);
    expect_done("nohalt", 193, 64, 1);
    pulse_start();
    wait_idle("nohalt");
    get_cell(1, v);
    check("nohalt cell1", v, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
